al_sequencer: RTL and testbench

Sequences the PROM-to-register auto-load on CLK40. It pops decoded parameter words from the PROM_Xfer readback FIFO and issues one AUTO_LOAD strobe per word with a matching AL_CNT. It validates the header word, retries through the slow-FIFO reset FSM on a bad header, and falls back to defaults after repeated failures. It sits between the reset manager (AL_START) and the PROM_Xfer FIFO, al_cdac and al_buckeye_load consumers.

---
 rtl/al_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_al_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/al_sequencer.sv
// PROM-to-register auto-load sequencer: pops readback FIFO words, strobes AUTO_LOAD per word, retries/defaults on bad header.
// Latency: AUTO_LOAD rises RD_LAT cycles after each PF_RD; one word every RD_LAT+3 cycles. Optional watchdog: AL_TIMEOUT_EN.
// Backpressure: holds in WAIT while PF_MT is high; FINISH/DFLT stall until CDAC_DONE & BSHIFT_DONE.
module al_sequencer #(
    parameter int          NWORDS    = 34,
    parameter logic [15:0] HEADER    = 16'h4321,
    parameter int          RD_LAT    = 2,
    parameter int          MAX_RETRY = 2
`ifdef AL_TIMEOUT_EN
    ,
    parameter int          TIMEOUT   = 4095
`endif
) (
    input  logic        CLK40,
    input  logic        RST,
    input  logic        AL_START,
    input  logic        SLOW_FIFO_RST_DONE,
    input  logic        PF_MT,
    input  logic [15:0] RBK_DATA,
    input  logic        CDAC_DONE,
    input  logic        BSHIFT_DONE,
    output logic        PF_RD,
    output logic        AUTO_LOAD,
    output logic        AUTO_LOAD_ENA,
    output logic [5:0]  AL_CNT,
    output logic        CLR_AL_DONE,
    output logic        AL_RESTART,
    output logic        LOAD_DFLT,
    output logic        AL_ABORT,
    output logic        AL_DONE,
    output logic [2:0]  AL_STATUS
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_LAT,
        S_CHK,
        S_NEXT,
        S_FINISH,
        S_RESTART,
        S_RST_LO,
        S_RST_HI,
        S_DFLT
    } state_t;

    localparam logic [5:0] LAST_CNT   = 6'(NWORDS - 1);
    localparam logic [2:0] STAT_IDLE  = 3'd0;
    localparam logic [2:0] STAT_LOAD  = 3'd1;
    localparam logic [2:0] STAT_OK    = 3'd2;
    localparam logic [2:0] STAT_RETRY = 3'd3;
    localparam logic [2:0] STAT_DFLT  = 3'd4;
`ifdef AL_TIMEOUT_EN
    localparam logic [2:0] STAT_TMO   = 3'd5;
`endif

    state_t      state, state_d;
    logic        start_q;
    logic [1:0]  lat, lat_d;
    logic [2:0]  retry, retry_d;
    logic [15:0] data_q, data_d;
    logic        pf_rd_d, auto_load_d, ena_d, clr_d, restart_d;
    logic        dflt_d, abort_d, done_d;
    logic [5:0]  cnt_d;
    logic [2:0]  status_d;
    logic        start_edge;
`ifdef AL_TIMEOUT_EN
    logic [11:0] wdog, wdog_d;
`endif

    assign start_edge = AL_START & ~start_q;

    always_comb begin
        state_d     = state;
        lat_d       = lat;
        retry_d     = retry;
        data_d      = data_q;
        pf_rd_d     = 1'b0;
        auto_load_d = 1'b0;
        clr_d       = 1'b0;
        restart_d   = 1'b0;
        ena_d       = AUTO_LOAD_ENA;
        cnt_d       = AL_CNT;
        dflt_d      = LOAD_DFLT;
        abort_d     = AL_ABORT;
        done_d      = AL_DONE;
        status_d    = AL_STATUS;
`ifdef AL_TIMEOUT_EN
        wdog_d      = 12'd0;
`endif
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    clr_d    = 1'b1;
                    ena_d    = 1'b1;
                    status_d = STAT_LOAD;
                    cnt_d    = 6'd0;
                    abort_d  = 1'b0;
                    dflt_d   = 1'b0;
                    done_d   = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef AL_TIMEOUT_EN
                if (wdog == 12'(TIMEOUT)) begin
                    status_d = STAT_TMO;
                    state_d  = S_RESTART;
                end else if (!PF_MT) begin
                    pf_rd_d = 1'b1;
                    lat_d   = 2'd1;
                    state_d = S_LAT;
                end else begin
                    wdog_d = wdog + 12'd1;
                end
`else
                if (!PF_MT) begin
                    pf_rd_d = 1'b1;
                    lat_d   = 2'd1;
                    state_d = S_LAT;
                end
`endif
            end
            S_LAT: begin
                // Capture completes even if the FIFO went empty behind the pop.
                if (lat == 2'(RD_LAT)) begin
                    auto_load_d = 1'b1;
                    data_d      = RBK_DATA;
                    state_d     = S_CHK;
                end else begin
                    lat_d = lat + 2'd1;
                end
            end
            S_CHK: begin
                if (AL_CNT == 6'd0 && data_q != HEADER) begin
                    abort_d  = 1'b1;
                    status_d = STAT_RETRY;
                    state_d  = S_RESTART;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (AL_CNT == LAST_CNT) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d   = AL_CNT + 6'd1;
                    state_d = S_WAIT;
                end
            end
            S_FINISH: begin
                if (CDAC_DONE && BSHIFT_DONE) begin
                    done_d   = 1'b1;
                    status_d = STAT_OK;
                    ena_d    = 1'b0;
                    retry_d  = 3'd0;
                    state_d  = S_IDLE;
                end
            end
            S_RESTART: begin
                if (retry < 3'(MAX_RETRY)) begin
                    retry_d   = retry + 3'd1;
                    restart_d = 1'b1;
                    state_d   = S_RST_LO;
                end else begin
                    dflt_d   = 1'b1;
                    status_d = STAT_DFLT;
                    state_d  = S_DFLT;
                end
            end
            S_RST_LO: begin
                if (!SLOW_FIFO_RST_DONE) begin
                    state_d = S_RST_HI;
                end
            end
            S_RST_HI: begin
                if (SLOW_FIFO_RST_DONE) begin
                    clr_d    = 1'b1;
                    cnt_d    = 6'd0;
                    abort_d  = 1'b0;
                    dflt_d   = 1'b0;
                    status_d = STAT_LOAD;
                    state_d  = S_WAIT;
                end
            end
            S_DFLT: begin
                // Retry budget is per load, so a later AL_START gets a fresh set of attempts.
                if (CDAC_DONE && BSHIFT_DONE) begin
                    done_d  = 1'b1;
                    ena_d   = 1'b0;
                    retry_d = 3'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        start_q <= AL_START;
        if (RST) begin
            state         <= S_IDLE;
            lat           <= 2'd0;
            retry         <= 3'd0;
            data_q        <= 16'd0;
            PF_RD         <= 1'b0;
            AUTO_LOAD     <= 1'b0;
            AUTO_LOAD_ENA <= 1'b0;
            AL_CNT        <= 6'd0;
            CLR_AL_DONE   <= 1'b0;
            AL_RESTART    <= 1'b0;
            LOAD_DFLT     <= 1'b0;
            AL_ABORT      <= 1'b0;
            AL_DONE       <= 1'b0;
            AL_STATUS     <= STAT_IDLE;
`ifdef AL_TIMEOUT_EN
            wdog          <= 12'd0;
`endif
        end else begin
            state         <= state_d;
            lat           <= lat_d;
            retry         <= retry_d;
            data_q        <= data_d;
            PF_RD         <= pf_rd_d;
            AUTO_LOAD     <= auto_load_d;
            AUTO_LOAD_ENA <= ena_d;
            AL_CNT        <= cnt_d;
            CLR_AL_DONE   <= clr_d;
            AL_RESTART    <= restart_d;
            LOAD_DFLT     <= dflt_d;
            AL_ABORT      <= abort_d;
            AL_DONE       <= done_d;
            AL_STATUS     <= status_d;
`ifdef AL_TIMEOUT_EN
            wdog          <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_al_sequencer.sv
// Directed bench for al_sequencer: PROM FIFO model, slow-FIFO reset responder and pulse monitor.
module tb_al_sequencer;

    localparam int          NW     = 34;
    localparam int          RD_LAT = 2;
    localparam logic [15:0] HDR    = 16'h4321;
    localparam logic [15:0] BAD    = 16'h1234;

    logic        CLK40 = 1'b0;
    logic        RST = 1'b1;
    logic        AL_START = 1'b0;
    logic        SLOW_FIFO_RST_DONE = 1'b1;
    logic        PF_MT = 1'b1;
    logic [15:0] RBK_DATA = 16'd0;
    logic        CDAC_DONE = 1'b1;
    logic        BSHIFT_DONE = 1'b1;
    logic        PF_RD, AUTO_LOAD, AUTO_LOAD_ENA, CLR_AL_DONE, AL_RESTART;
    logic        LOAD_DFLT, AL_ABORT, AL_DONE;
    logic [5:0]  AL_CNT;
    logic [2:0]  AL_STATUS;

    al_sequencer dut (
        .CLK40(CLK40), .RST(RST), .AL_START(AL_START),
        .SLOW_FIFO_RST_DONE(SLOW_FIFO_RST_DONE), .PF_MT(PF_MT), .RBK_DATA(RBK_DATA),
        .CDAC_DONE(CDAC_DONE), .BSHIFT_DONE(BSHIFT_DONE), .PF_RD(PF_RD),
        .AUTO_LOAD(AUTO_LOAD), .AUTO_LOAD_ENA(AUTO_LOAD_ENA), .AL_CNT(AL_CNT),
        .CLR_AL_DONE(CLR_AL_DONE), .AL_RESTART(AL_RESTART), .LOAD_DFLT(LOAD_DFLT),
        .AL_ABORT(AL_ABORT), .AL_DONE(AL_DONE), .AL_STATUS(AL_STATUS)
    );

    always #5 CLK40 = ~CLK40;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    logic [15:0] fifo_q[$];
    logic [15:0] hdr_seq[$];
    int          al_log[$];
    logic [15:0] dat_log[$];
    int cyc = 0, last_rd = 0, pfrd_n = 0, al_n = 0, clr_n = 0, rs_n = 0;
    int lat_bad = 0, b2b = 0, rs_status = 0, rs_abort = 0, sfr_timer = 0;
    logic prev_rd = 1'b0;

    task automatic push_words(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) fifo_q.push_back(16'h1000 + 16'(i));
    endtask

    task automatic load_image(input logic [15:0] hdr);
        fifo_q.push_back(hdr);
        push_words(1, NW - 1);
    endtask

    task automatic clear_mon();
        al_log.delete(); dat_log.delete();
        pfrd_n = 0; al_n = 0; clr_n = 0; rs_n = 0; lat_bad = 0; b2b = 0;
    endtask

    function automatic int seq_errs(input int start);
        int e = 0;
        for (int i = start; i < al_log.size(); i++) if (al_log[i] != i - start) e++;
        return e;
    endfunction

    // Environment: sample DUT outputs, then act as readback FIFO and slow-FIFO reset FSM.
    always @(negedge CLK40) begin
        cyc++;
        if (PF_RD) begin
            pfrd_n++;
            if (prev_rd) b2b++;
            last_rd = cyc;
        end
        prev_rd = PF_RD;
        if (AUTO_LOAD) begin
            if (cyc - last_rd != RD_LAT) lat_bad++;
            al_log.push_back(int'(AL_CNT));
            dat_log.push_back(RBK_DATA);
            al_n++;
        end
        if (CLR_AL_DONE) clr_n++;
        if (PF_RD && fifo_q.size() > 0) RBK_DATA = fifo_q.pop_front();
        if (AL_RESTART) begin
            rs_n++;
            rs_status = int'(AL_STATUS);
            rs_abort  = int'(AL_ABORT);
            fifo_q.delete();
            SLOW_FIFO_RST_DONE = 1'b0;
            sfr_timer = 4;
        end else if (sfr_timer > 0) begin
            sfr_timer--;
            if (sfr_timer == 0) begin
                load_image(hdr_seq.size() > 0 ? hdr_seq.pop_front() : HDR);
                SLOW_FIFO_RST_DONE = 1'b1;
            end
        end
        PF_MT = (fifo_q.size() == 0);
    end

    task automatic pulse_start();
        AL_START = 1'b0;
        @(negedge CLK40); @(negedge CLK40);
        AL_START = 1'b1;
        @(negedge CLK40);
    endtask

    task automatic wait_al(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && al_n < n; i++) @(negedge CLK40);
        check_eq(tag, int'(al_n >= n), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !AL_DONE; i++) @(negedge CLK40);
        check_eq(tag, int'(AL_DONE), 1);
    endtask

    function automatic int ctl_bits();
        return int'({PF_RD, AUTO_LOAD, AUTO_LOAD_ENA, CLR_AL_DONE, AL_RESTART,
                     LOAD_DFLT, AL_ABORT, AL_DONE});
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge CLK40);
        check_eq("rst_ctl", ctl_bits(), 0);
        check_eq("rst_cnt", int'(AL_CNT), 0);
        check_eq("rst_status", int'(AL_STATUS), 0);
        RST = 1'b0;
        @(negedge CLK40);

        // Good load, completion gated by the DONE inputs, AL_START toggled mid-load
        CDAC_DONE = 1'b0; BSHIFT_DONE = 1'b0;
        clear_mon();
        load_image(HDR);
        pulse_start();
        check_eq("good_clr", int'(CLR_AL_DONE), 1);
        check_eq("good_ena", int'(AUTO_LOAD_ENA), 1);
        check_eq("good_stat1", int'(AL_STATUS), 1);
        repeat (20) @(negedge CLK40);
        AL_START = 1'b0;
        repeat (3) @(negedge CLK40);
        AL_START = 1'b1;
        wait_al("good_tmo", NW, 1000);
        repeat (5) @(negedge CLK40);
        check_eq("good_hold_done", int'(AL_DONE), 0);
        check_eq("good_hold_ena", int'(AUTO_LOAD_ENA), 1);
        CDAC_DONE = 1'b1; BSHIFT_DONE = 1'b1;
        wait_done("good_done", 20);
        check_eq("good_status", int'(AL_STATUS), 2);
        check_eq("good_dflt", int'(LOAD_DFLT), 0);
        check_eq("good_ena_off", int'(AUTO_LOAD_ENA), 0);
        check_eq("good_al_n", al_n, NW);
        check_eq("good_seq", seq_errs(0), 0);
        check_eq("good_last_dat", int'(dat_log[NW - 1]), 16'h1021);
        check_eq("good_hdr_dat", int'(dat_log[0]), int'(HDR));
        check_eq("good_pfrd_n", pfrd_n, NW);
        check_eq("good_latency", lat_bad, 0);
        check_eq("good_b2b", b2b, 0);
        check_eq("good_one_clr", clr_n, 1);

        // Bad header then good
        clear_mon();
        hdr_seq.delete(); hdr_seq.push_back(HDR);
        load_image(BAD);
        pulse_start();
        wait_done("retry_done", 2000);
        check_eq("retry_rs_n", rs_n, 1);
        check_eq("retry_rs_stat", rs_status, 3);
        check_eq("retry_rs_abort", rs_abort, 1);
        check_eq("retry_status", int'(AL_STATUS), 2);
        check_eq("retry_abort", int'(AL_ABORT), 0);
        check_eq("retry_clr_n", clr_n, 2);
        check_eq("retry_al_n", al_n, NW + 1);
        check_eq("retry_seq", seq_errs(1), 0);

        // Bad header three times -> defaults
        clear_mon();
        hdr_seq.delete(); hdr_seq.push_back(BAD); hdr_seq.push_back(BAD);
        load_image(BAD);
        pulse_start();
        wait_done("dflt_done", 2000);
        check_eq("dflt_rs_n", rs_n, 2);
        check_eq("dflt_flag", int'(LOAD_DFLT), 1);
        check_eq("dflt_status", int'(AL_STATUS), 4);
        check_eq("dflt_al_n", al_n, 3);
        check_eq("dflt_ena", int'(AUTO_LOAD_ENA), 0);
        check_eq("dflt_clr_n", clr_n, 3);

        // FIFO starvation at word 10
        clear_mon();
        hdr_seq.delete();
        repeat (10) @(negedge CLK40);
        fifo_q.delete();
        fifo_q.push_back(HDR);
        push_words(1, 9);
        pulse_start();
        check_eq("starve_dflt_clr", int'(LOAD_DFLT), 0);
        wait_al("starve_tmo", 10, 500);
        repeat (500) @(negedge CLK40);
        check_eq("starve_pfrd_n", pfrd_n, 10);
        check_eq("starve_cnt", int'(AL_CNT), 10);
        check_eq("starve_status", int'(AL_STATUS), 1);
        push_words(10, NW - 1);
        wait_done("starve_done", 1000);
        check_eq("starve_al_n", al_n, NW);
        check_eq("starve_seq", seq_errs(0), 0);
        check_eq("starve_status2", int'(AL_STATUS), 2);

        // Reset mid-load at AL_CNT=17, then a fresh load
        fifo_q.delete();
        load_image(HDR);
        pulse_start();
        for (int i = 0; i < 1000 && AL_CNT != 6'd17; i++) @(negedge CLK40);
        check_eq("rstmid_reach", int'(AL_CNT), 17);
        RST = 1'b1;
        @(negedge CLK40);
        check_eq("rstmid_ctl", ctl_bits(), 0);
        check_eq("rstmid_cnt", int'(AL_CNT), 0);
        check_eq("rstmid_status", int'(AL_STATUS), 0);
        RST = 1'b0;
        fifo_q.delete();
        load_image(HDR);
        @(negedge CLK40);
        clear_mon();
        pulse_start();
        check_eq("rstmid_clr", int'(CLR_AL_DONE), 1);
        check_eq("rstmid_cnt0", int'(AL_CNT), 0);
        wait_done("rstmid_done", 1000);
        check_eq("rstmid_al_n", al_n, NW);
        check_eq("rstmid_seq", seq_errs(0), 0);
        check_eq("rstmid_status2", int'(AL_STATUS), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
